biquad_scheduler: RTL and testbench

Time-multiplexed controller that runs NUM_BANDS cascaded Q2.14 biquad sections on one shared 16x16 signed multiplier and one accumulator, once per incoming audio sample. It owns a double-buffered coefficient bank, loaded from the MCU/SPI side, and per-band history state. It swaps coefficients only at sample boundaries so the MCU can retune without glitches. It sits between the I2S receive path and the I2S transmit path.

---
 rtl/biquad_pkg.sv | 45 ++++
 rtl/biquad_scheduler_if.sv | 53 +++++
 rtl/biquad_coef_bank.sv | 83 ++++++++
 rtl/biquad_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_biquad_scheduler.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/biquad_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : biquad_pkg
//  Description : Shared constants and types for the time-multiplexed biquad
//                scheduler: Q2.14 scaling, coefficient slot indices, FSM
//                state encoding and output saturation limits.
//  Revision    : 1.0  initial release
// ============================================================================
package biquad_pkg;

    // Q2.14 fixed point: 1.0 is represented as 2^14.
    localparam int FRAC_BITS = 14;
    localparam int COEF_ONE  = 16384;

    // Five coefficient slots per band.
    localparam int NUM_COEFS = 5;

    // Output sample limits (16-bit signed samples).
    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    // Coefficient slot index, matching the write-port encoding.
    typedef enum logic [2:0] {
        B0 = 3'd0,
        B1 = 3'd1,
        B2 = 3'd2,
        A1 = 3'd3,
        A2 = 3'd4
    } coef_idx_e;

    // Scheduler states: one band is LOAD, MAC0..MAC4, WRITE (7 cycles).
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOAD  = 4'd1,
        ST_MAC0  = 4'd2,
        ST_MAC1  = 4'd3,
        ST_MAC2  = 4'd4,
        ST_MAC3  = 4'd5,
        ST_MAC4  = 4'd6,
        ST_WRITE = 4'd7,
        ST_DONE  = 4'd8
    } state_e;

endpackage
`default_nettype wire

// File: rtl/biquad_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Interface   : biquad_scheduler_if
//  Description : Sample, coefficient-programming and status signals of the
//                biquad scheduler.
//                master : sample source / MCU side (drives inputs)
//                slave  : the scheduler itself
//  Signals     : sample_in/sample_valid/band_bypass  - incoming sample
//                coef_wr_* / coef_commit             - shadow bank programming
//                coef_pending                        - commit not yet applied
//                sample_out/out_valid/busy           - result and activity
//                clip_flag/overrun/flag_clear        - sticky status flags
//  Revision    : 1.0  initial release
// ============================================================================
interface biquad_scheduler_if #(
    parameter int NUM_BANDS = 4,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16
);
    localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_valid;
    logic [NUM_BANDS-1:0]     band_bypass;
    logic                     coef_wr_en;
    logic [BAND_W-1:0]        coef_wr_band;
    logic [2:0]               coef_wr_idx;
    logic signed [COEF_W-1:0] coef_wr_data;
    logic                     coef_commit;
    logic                     coef_pending;
    logic signed [DATA_W-1:0] sample_out;
    logic                     out_valid;
    logic                     busy;
    logic                     clip_flag;
    logic                     overrun;
    logic                     flag_clear;

    modport master (
        output sample_in, sample_valid, band_bypass,
        output coef_wr_en, coef_wr_band, coef_wr_idx, coef_wr_data, coef_commit,
        output flag_clear,
        input  coef_pending, sample_out, out_valid, busy, clip_flag, overrun
    );

    modport slave (
        input  sample_in, sample_valid, band_bypass,
        input  coef_wr_en, coef_wr_band, coef_wr_idx, coef_wr_data, coef_commit,
        input  flag_clear,
        output coef_pending, sample_out, out_valid, busy, clip_flag, overrun
    );

endinterface
`default_nettype wire

// File: rtl/biquad_coef_bank.sv
`default_nettype none
// ============================================================================
//  Module      : biquad_coef_bank
//  Description : Double-buffered coefficient store. Writes land in the
//                shadow bank; a swap copies the whole shadow bank (including
//                a write in the same cycle) into the active bank atomically.
//  Ports       : clk, reset                 - clock, async active-high reset
//                wr_en_i/wr_band_i/wr_idx_i/wr_data_i - shadow write port
//                commit_i                   - request a swap (sets pending)
//                swap_i                     - perform the swap now
//                rd_band_i/rd_idx_i/rd_data_o - active bank read port
//                pending_o                  - commit requested, not applied
//  Revision    : 1.0  initial release
// ============================================================================
module biquad_coef_bank
    import biquad_pkg::*;
#(
    parameter int NUM_BANDS = 4,
    parameter int COEF_W    = 16,
    parameter int BAND_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en_i,
    input  logic [BAND_W-1:0]        wr_band_i,
    input  logic [2:0]               wr_idx_i,
    input  logic signed [COEF_W-1:0] wr_data_i,
    input  logic                     commit_i,
    input  logic                     swap_i,
    input  logic [BAND_W-1:0]        rd_band_i,
    input  coef_idx_e                rd_idx_i,
    output logic signed [COEF_W-1:0] rd_data_o,
    output logic                     pending_o
);

    localparam logic signed [COEF_W-1:0] ONE_Q = COEF_W'(COEF_ONE);

    logic signed [COEF_W-1:0] shadow_q [NUM_BANDS][NUM_COEFS];
    logic signed [COEF_W-1:0] shadow_d [NUM_BANDS][NUM_COEFS];
    logic signed [COEF_W-1:0] active_q [NUM_BANDS][NUM_COEFS];
    logic                     pending_q;
    logic                     wr_ok_w;

    // Out-of-range slot or band addresses are silently dropped.
    assign wr_ok_w = wr_en_i
                   && (32'(wr_idx_i) < NUM_COEFS)
                   && (32'(wr_band_i) < NUM_BANDS);

    always_comb begin
        shadow_d = shadow_q;
        if (wr_ok_w) begin
            shadow_d[wr_band_i][wr_idx_i] = wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                for (int i = 0; i < NUM_COEFS; i++) begin
                    shadow_q[b][i] <= (i == 0) ? ONE_Q : '0;
                    active_q[b][i] <= (i == 0) ? ONE_Q : '0;
                end
            end
            pending_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            // Swap from shadow_d so a write in the swap cycle is included.
            if (swap_i) begin
                active_q <= shadow_d;
            end
            if (swap_i) begin
                pending_q <= 1'b0;
            end else if (commit_i) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign rd_data_o = active_q[rd_band_i][rd_idx_i];
    assign pending_o = pending_q;

endmodule
`default_nettype wire

// File: rtl/biquad_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : biquad_scheduler
//  Description : Runs NUM_BANDS cascaded Q2.14 biquads per input sample on a
//                single shared multiplier and accumulator. Each band takes
//                7 cycles (LOAD, 5 MACs, WRITE); coefficients swap from the
//                shadow bank only when a sample is accepted.
//  Ports       : clk    - system clock
//                reset  - asynchronous, active-high reset
//                bus    - biquad_scheduler_if.slave (sample, coefficient
//                         programming and status signals)
//  Revision    : 1.0  initial release
// ============================================================================
module biquad_scheduler
    import biquad_pkg::*;
#(
    parameter int NUM_BANDS = 4,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int ACC_W     = 36
) (
    input  logic               clk,
    input  logic               reset,
    biquad_scheduler_if.slave  bus
);

    localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(SAT_MIN);
    localparam logic [BAND_W-1:0]       LAST_BAND = BAND_W'(NUM_BANDS - 1);

    state_e                   state_q;
    logic [BAND_W-1:0]        band_q;
    logic [NUM_BANDS-1:0]     bypass_q;
    logic signed [DATA_W-1:0] xcur_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [DATA_W-1:0] hx1_q, hx2_q, hy1_q, hy2_q;
    logic signed [DATA_W-1:0] x1_q [NUM_BANDS];
    logic signed [DATA_W-1:0] x2_q [NUM_BANDS];
    logic signed [DATA_W-1:0] y1_q [NUM_BANDS];
    logic signed [DATA_W-1:0] y2_q [NUM_BANDS];
    logic signed [DATA_W-1:0] sample_out_q;
    logic                     out_valid_q;
    logic                     busy_q;
    logic                     clip_q;
    logic                     overrun_q;

    logic                     accept_w;
    logic                     swap_w;
    logic                     pending_w;
    coef_idx_e                rd_idx_w;
    logic signed [COEF_W-1:0] coef_w;
    logic signed [DATA_W-1:0] mul_b_w;
    logic signed [PROD_W-1:0] prod_w;
    logic signed [ACC_W-1:0]  prod_ext_w;
    logic signed [ACC_W-1:0]  acc_next_w;
    logic signed [ACC_W-1:0]  acc_shift_w;
    logic signed [DATA_W-1:0] y_sat_w;
    logic                     sat_w;
    logic                     band_bypass_w;
    logic signed [DATA_W-1:0] band_y_w;
    logic                     clip_set_w;
    logic                     ovr_set_w;

    assign accept_w = (state_q == ST_IDLE) && bus.sample_valid;
    // A commit raised in the acceptance cycle itself still takes effect.
    assign swap_w   = accept_w && (pending_w || bus.coef_commit);

    biquad_coef_bank #(
        .NUM_BANDS (NUM_BANDS),
        .COEF_W    (COEF_W),
        .BAND_W    (BAND_W)
    ) u_coef_bank (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (bus.coef_wr_en),
        .wr_band_i (bus.coef_wr_band),
        .wr_idx_i  (bus.coef_wr_idx),
        .wr_data_i (bus.coef_wr_data),
        .commit_i  (bus.coef_commit),
        .swap_i    (swap_w),
        .rd_band_i (band_q),
        .rd_idx_i  (rd_idx_w),
        .rd_data_o (coef_w),
        .pending_o (pending_w)
    );

    // Operand selection for the shared multiplier, one term per MAC state.
    always_comb begin
        rd_idx_w = B0;
        mul_b_w  = xcur_q;
        case (state_q)
            ST_MAC1: begin rd_idx_w = B1; mul_b_w = hx1_q; end
            ST_MAC2: begin rd_idx_w = B2; mul_b_w = hx2_q; end
            ST_MAC3: begin rd_idx_w = A1; mul_b_w = hy1_q; end
            ST_MAC4: begin rd_idx_w = A2; mul_b_w = hy2_q; end
            default: begin rd_idx_w = B0; mul_b_w = xcur_q; end
        endcase
    end

    assign prod_w     = PROD_W'(coef_w) * PROD_W'(mul_b_w);
    assign prod_ext_w = ACC_W'(prod_w);
    // Feedback terms enter with a negative sign.
    assign acc_next_w = ((state_q == ST_MAC3) || (state_q == ST_MAC4))
                      ? (acc_q - prod_ext_w) : (acc_q + prod_ext_w);

    assign acc_shift_w = acc_q >>> FRAC_BITS;

    always_comb begin
        y_sat_w = acc_shift_w[DATA_W-1:0];
        sat_w   = 1'b0;
        if (acc_shift_w > SAT_HI) begin
            y_sat_w = DATA_W'(SAT_MAX);
            sat_w   = 1'b1;
        end else if (acc_shift_w < SAT_LO) begin
            y_sat_w = DATA_W'(SAT_MIN);
            sat_w   = 1'b1;
        end
    end

    assign band_bypass_w = bypass_q[band_q];
    assign band_y_w      = band_bypass_w ? xcur_q : y_sat_w;
    assign clip_set_w    = (state_q == ST_WRITE) && !band_bypass_w && sat_w;
    assign ovr_set_w     = bus.sample_valid && (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            band_q       <= '0;
            bypass_q     <= '0;
            xcur_q       <= '0;
            acc_q        <= '0;
            hx1_q        <= '0;
            hx2_q        <= '0;
            hy1_q        <= '0;
            hy2_q        <= '0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                x1_q[b] <= '0;
                x2_q[b] <= '0;
                y1_q[b] <= '0;
                y2_q[b] <= '0;
            end
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            clip_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            // A new event wins over a simultaneous clear.
            clip_q    <= clip_set_w || (clip_q && !bus.flag_clear);
            overrun_q <= ovr_set_w  || (overrun_q && !bus.flag_clear);

            case (state_q)
                ST_IDLE: begin
                    if (accept_w) begin
                        xcur_q   <= bus.sample_in;
                        bypass_q <= bus.band_bypass;
                        band_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    acc_q   <= '0;
                    hx1_q   <= x1_q[band_q];
                    hx2_q   <= x2_q[band_q];
                    hy1_q   <= y1_q[band_q];
                    hy2_q   <= y2_q[band_q];
                    state_q <= ST_MAC0;
                end
                ST_MAC0: begin acc_q <= acc_next_w; state_q <= ST_MAC1;  end
                ST_MAC1: begin acc_q <= acc_next_w; state_q <= ST_MAC2;  end
                ST_MAC2: begin acc_q <= acc_next_w; state_q <= ST_MAC3;  end
                ST_MAC3: begin acc_q <= acc_next_w; state_q <= ST_MAC4;  end
                ST_MAC4: begin acc_q <= acc_next_w; state_q <= ST_WRITE; end
                ST_WRITE: begin
                    if (band_bypass_w) begin
                        x1_q[band_q] <= '0;
                        x2_q[band_q] <= '0;
                        y1_q[band_q] <= '0;
                        y2_q[band_q] <= '0;
                    end else begin
                        x2_q[band_q] <= hx1_q;
                        x1_q[band_q] <= xcur_q;
                        y2_q[band_q] <= hy1_q;
                        y1_q[band_q] <= y_sat_w;
                    end
                    // This band's output feeds the next band.
                    xcur_q <= band_y_w;
                    if (band_q == LAST_BAND) begin
                        sample_out_q <= band_y_w;
                        out_valid_q  <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        band_q  <= band_q + BAND_W'(1);
                        state_q <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.coef_pending = pending_w;
    assign bus.sample_out   = sample_out_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.busy         = busy_q;
    assign bus.clip_flag    = clip_q;
    assign bus.overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_biquad_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_biquad_scheduler
//  Description : Directed self-checking bench for biquad_scheduler with
//                hand-computed expected outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_biquad_scheduler;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    biquad_scheduler_if #(.NUM_BANDS(4), .DATA_W(16), .COEF_W(16)) bus ();

    biquad_scheduler #(
        .NUM_BANDS (4),
        .DATA_W    (16),
        .COEF_W    (16),
        .ACC_W     (36)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_coef(input int band, input int idx, input int val, input bit commit);
        @(negedge clk);
        bus.coef_wr_en   = 1'b1;
        bus.coef_wr_band = 2'(band);
        bus.coef_wr_idx  = 3'(idx);
        bus.coef_wr_data = 16'(val);
        bus.coef_commit  = commit;
        @(negedge clk);
        bus.coef_wr_en   = 1'b0;
        bus.coef_commit  = 1'b0;
    endtask

    task automatic commit_pulse();
        @(negedge clk);
        bus.coef_commit = 1'b1;
        @(negedge clk);
        bus.coef_commit = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.flag_clear = 1'b1;
        @(negedge clk);
        bus.flag_clear = 1'b0;
    endtask

    // Sends one sample (scheduler assumed idle) and waits for its result.
    // lat counts clock edges from the acceptance edge (inclusive) until
    // out_valid is seen.
    task automatic send(input int x, input logic [3:0] byp,
                        output int y, output int lat, output logic pend);
        @(negedge clk);
        bus.sample_in    = 16'(x);
        bus.band_bypass  = byp;
        bus.sample_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        pend = bus.coef_pending;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_val("out_valid_seen", longint'(bus.out_valid), 1);
        y = int'(bus.sample_out);
    endtask

    int          y;
    int          lat;
    logic        pend;
    int          seen;
    int          imp_in  [4];
    int          imp_exp [4];

    initial begin
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.band_bypass  = '0;
        bus.coef_wr_en   = 1'b0;
        bus.coef_wr_band = '0;
        bus.coef_wr_idx  = '0;
        bus.coef_wr_data = '0;
        bus.coef_commit  = 1'b0;
        bus.flag_clear   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check_val("rst_sample_out", longint'(bus.sample_out), 0);
        check_val("rst_out_valid", longint'(bus.out_valid), 0);
        check_val("rst_busy", longint'(bus.busy), 0);
        check_val("rst_pending", longint'(bus.coef_pending), 0);
        check_val("rst_clip", longint'(bus.clip_flag), 0);
        check_val("rst_overrun", longint'(bus.overrun), 0);
        reset = 1'b0;

        // 1: default passthrough and latency
        send(1000, 4'b0000, y, lat, pend);
        check_val("t1_out", y, 1000);
        check_val("t1_latency", lat, 29);
        @(negedge clk);
        check_val("t1_busy_after", longint'(bus.busy), 0);

        // 2: shadow write without commit has no effect; commit applies it
        write_coef(0, 0, 8192, 1'b0);
        check_val("t2_pend_nocommit", longint'(bus.coef_pending), 0);
        send(1000, 4'b0000, y, lat, pend);
        check_val("t2_out_nocommit", y, 1000);
        commit_pulse();
        check_val("t2_pend_set", longint'(bus.coef_pending), 1);
        send(1000, 4'b0000, y, lat, pend);
        check_val("t2_pend_cleared", longint'(pend), 0);
        check_val("t2_out_half", y, 500);
        send(-1001, 4'b0000, y, lat, pend);
        check_val("t2_neg_trunc", y, -501);
        // Slot index 5 does not exist and must be ignored.
        write_coef(0, 5, 0, 1'b1);
        send(1000, 4'b0000, y, lat, pend);
        check_val("t2_bad_idx", y, 500);

        // 3: FIR 1+z^-1+z^-2 on band 0, then bypass clears history
        do_reset();
        write_coef(0, 1, 16384, 1'b0);
        write_coef(0, 2, 16384, 1'b1);
        imp_in  = '{1000, 0, 0, 0};
        imp_exp = '{1000, 1000, 1000, 0};
        for (int k = 0; k < 4; k++) begin
            send(imp_in[k], 4'b0000, y, lat, pend);
            check_val($sformatf("t3_fir_%0d", k), y, imp_exp[k]);
        end
        send(1000, 4'b0000, y, lat, pend);
        check_val("t3_pre_bypass", y, 1000);
        send(700, 4'b0001, y, lat, pend);
        check_val("t3_bypass_out", y, 700);
        send(0, 4'b0000, y, lat, pend);
        check_val("t3_hist_cleared", y, 0);

        // 4: single-pole feedback, a1 = -0.5
        do_reset();
        write_coef(0, 3, -8192, 1'b1);
        imp_in  = '{1024, 0, 0, 0};
        imp_exp = '{1024, 512, 256, 128};
        for (int k = 0; k < 4; k++) begin
            send(imp_in[k], 4'b0000, y, lat, pend);
            check_val($sformatf("t4_iir_%0d", k), y, imp_exp[k]);
        end

        // 5: saturation in both directions and sticky clip flag
        do_reset();
        write_coef(0, 0, 32767, 1'b1);
        send(30000, 4'b0000, y, lat, pend);
        check_val("t5_sat_pos", y, 32767);
        check_val("t5_clip_set", longint'(bus.clip_flag), 1);
        pulse_clear();
        check_val("t5_clip_cleared", longint'(bus.clip_flag), 0);
        send(-30000, 4'b0000, y, lat, pend);
        check_val("t5_sat_neg", y, -32768);
        check_val("t5_clip_set_neg", longint'(bus.clip_flag), 1);

        // 6: overrun while busy, clear/set collision, output intact
        do_reset();
        @(negedge clk);
        bus.sample_in    = 16'sd1000;
        bus.sample_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        bus.sample_in    = 16'sd7777;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        check_val("t6_overrun_set", longint'(bus.overrun), 1);
        check_val("t6_busy", longint'(bus.busy), 1);
        bus.sample_valid = 1'b1;
        bus.flag_clear   = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.flag_clear   = 1'b0;
        check_val("t6_set_beats_clear", longint'(bus.overrun), 1);
        bus.flag_clear = 1'b1;
        @(negedge clk);
        bus.flag_clear = 1'b0;
        check_val("t6_overrun_cleared", longint'(bus.overrun), 0);
        seen = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check_val("t6_out_valid", seen, 1);
        check_val("t6_out", longint'(bus.sample_out), 1000);

        // 6b: reset in the middle of a sample aborts it
        @(negedge clk);
        bus.sample_in    = 16'sd2000;
        bus.sample_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("t6_rst_sample_out", longint'(bus.sample_out), 0);
        check_val("t6_rst_out_valid", longint'(bus.out_valid), 0);
        check_val("t6_rst_busy", longint'(bus.busy), 0);
        check_val("t6_rst_overrun", longint'(bus.overrun), 0);
        check_val("t6_rst_clip", longint'(bus.clip_flag), 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check_val("t6_no_out_after_abort", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
